// File: rtl/bfm_pkg.sv
// Shared types and limits for the adder stimulus/checker BFM.
package bfm_pkg;

    localparam int LATENCY_MAX = 8;
    localparam int DEF_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bfm_state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/bfm_sync_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module bfm_sync_fifo #(
    parameter int WIDTH2 = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH2-1:0] wdata,
    output logic [WIDTH2-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [WIDTH2-1:0] mem_r [DEPTH];
    logic              wr_en_s;
    logic              rd_en_s;

    // A push while full is dropped, so full is judged before this cycle's pop.
    assign wr_en_s = push & ~full;
    assign rd_en_s = pop & ~empty;
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign rdata   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (rd_en_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bfm_add_driver.sv
// Adder BFM: FIFO-buffered operand issue, expected-sum scoreboard pipe,
// registered result stream and saturating pass/fail counters.
module bfm_add_driver
    import bfm_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clr_cnt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_x,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_match,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int LAT = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    bfm_state_t       state_r;
    bfm_state_t       state_nxt_s;
    logic             done_nxt_s;
    logic             full_s;
    logic             empty_s;
    logic             issue_s;
    pair_t            push_pair_s;
    pair_t            head_pair_s;
    logic [WIDTH-1:0] sum_s;
    logic [LAT:0]     pipe_vld_r;
    logic [WIDTH-1:0] pipe_exp_r [LAT+1];
    logic             inflight_s;
    logic             chk_vld_s;
    logic             chk_match_s;

    assign push_pair_s = '{a: in_a, b: in_b};

    bfm_sync_fifo #(
        .WIDTH2 (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (issue_s),
        .wdata (push_pair_s),
        .rdata (head_pair_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign in_ready    = ~full_s;
    assign busy        = (state_r != IDLE);
    assign issue_s     = (state_r == RUN) && !empty_s;
    assign sum_s       = head_pair_s.a + head_pair_s.b;
    assign inflight_s  = |pipe_vld_r;
    // The last pipe stage lines up with the DUT output for the operands issued LAT cycles earlier.
    assign chk_vld_s   = pipe_vld_r[LAT];
    assign chk_match_s = (dut_x == pipe_exp_r[LAT]);

    // FSM state and done pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done    <= done_nxt_s;
        end
    end

    // FSM next state; re-enabling during DRAIN returns to RUN without a done pulse
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (enable) state_nxt_s = RUN;
                else        state_nxt_s = IDLE;
            end
            RUN: begin
                if (!enable) state_nxt_s = DRAIN;
                else         state_nxt_s = RUN;
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt_s = RUN;
                end else if (!inflight_s) begin
                    state_nxt_s = IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand drive; holds the last issued pair between issues
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dut_a <= '0;
            dut_b <= '0;
        end else if (issue_s) begin
            dut_a <= head_pair_s.a;
            dut_b <= head_pair_s.b;
        end
    end

    // Scoreboard pipe; shifts every cycle so non-issue cycles become bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld_r <= '0;
            for (int k = 0; k <= LAT; k++) pipe_exp_r[k] <= '0;
        end else begin
            pipe_vld_r[0] <= issue_s;
            pipe_exp_r[0] <= sum_s;
            for (int k = 1; k <= LAT; k++) begin
                pipe_vld_r[k] <= pipe_vld_r[k-1];
                pipe_exp_r[k] <= pipe_exp_r[k-1];
            end
        end
    end

    // Result stream register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_match <= 1'b0;
        end else begin
            res_valid <= chk_vld_s;
            if (chk_vld_s) begin
                res_data  <= dut_x;
                res_match <= chk_match_s;
            end
        end
    end

    // Saturating pass/fail counters; clear takes priority over a same-cycle result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr_cnt) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (chk_vld_s) begin
            if (chk_match_s) pass_cnt <= sat_inc(pass_cnt);
            else             fail_cnt <= sat_inc(fail_cnt);
        end
    end

endmodule
